seq_detect_ctrl: RTL and testbench

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_ctrl_if.sv | 30 +++
 rtl/seq_detect_ctrl.sv | 101 ++++++++++
 tb/tb_seq_detect_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: configuration handshake, run control, serial data and status of seq_detect_ctrl.
interface seq_detect_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_limit;
    logic               cfg_err;
    logic               start;
    logic               stop;
    logic               din_valid;
    logic               din;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;
    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit, start, stop, din_valid, din,
        input  cfg_ready, cfg_err, match, match_count, busy, done
    );
    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit, start, stop, din_valid, din,
        output cfg_ready, cfg_err, match, match_count, busy, done
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: configurable serial pattern detector with overlap mode and match-count limit.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    seq_detect_ctrl_if.slave  bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state;
    logic               loaded;
    logic [MAX_LEN-1:0] pattern;
    logic [LW-1:0]      len;
    logic               overlap;
    logic [CNT_W-1:0]   limit;
    logic [MAX_LEN-1:0] hist;
    logic [LW-1:0]      fill;
    logic [CNT_W-1:0]   count;
    logic               match_r;
    logic               done_r;
    logic               err_r;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] mask;
    logic [LW-1:0]      fill_n;
    logic [CNT_W-1:0]   cnt_inc;
    logic               hit;
    always_comb begin
        hist_n  = MAX_LEN'({hist, bus.din});
        fill_n  = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
        for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len));
        hit     = (fill_n >= len) && (((hist_n ^ pattern) & mask) == '0);
        cnt_inc = (&count) ? count : count + CNT_W'(1);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            loaded  <= 1'b0;
            pattern <= '0;
            len     <= '0;
            overlap <= 1'b0;
            limit   <= '0;
            hist    <= '0;
            fill    <= '0;
            count   <= '0;
            match_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            match_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cfg_valid) begin
                        if (bus.cfg_len != '0 && int'(bus.cfg_len) <= MAX_LEN) begin
                            pattern <= bus.cfg_pattern;
                            len     <= bus.cfg_len;
                            overlap <= bus.cfg_overlap;
                            limit   <= bus.cfg_limit;
                            loaded  <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                    if (bus.start && !bus.stop && loaded) begin
                        state <= RUN;
                        hist  <= '0;
                        fill  <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state <= IDLE;
                    end else if (bus.din_valid) begin
                        hist    <= hist_n;
                        // non-overlapping mode needs len fresh bits after every match
                        fill    <= (hit && !overlap) ? '0 : fill_n;
                        match_r <= hit;
                        if (hit) begin
                            count <= cnt_inc;
                            if (limit != '0 && cnt_inc == limit) begin
                                state  <= DONE;
                                done_r <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.cfg_ready   = (state == IDLE);
    assign bus.busy        = (state == RUN);
    assign bus.match       = match_r;
    assign bus.done        = done_r;
    assign bus.cfg_err     = err_r;
    assign bus.match_count = count;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed scenario tests for seq_detect_ctrl with hand-computed expectations.
module tb_seq_detect_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int tests_run = 0;
    int fails = 0;
    always #5 clk = ~clk;
    seq_detect_ctrl_if #(.MAX_LEN(8), .CNT_W(8)) bus ();
    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] lim);
        bus.cfg_valid = 1'b1; bus.cfg_pattern = p; bus.cfg_len = l; bus.cfg_overlap = o; bus.cfg_limit = lim;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic s);
        bus.start = 1'b1; bus.stop = s;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.stop = 1'b0;
    endtask

    task automatic beat(input logic b, input logic s);
        bus.din_valid = 1'b1; bus.din = b; bus.stop = s;
        @(posedge clk); #1;
        bus.din_valid = 1'b0; bus.stop = 1'b0;
    endtask

    // drives bits[n-1] first; records outputs seen after each beat in the same bit order
    task automatic stream(input logic [7:0] bits, input int n, output logic [7:0] m, output logic [7:0] d, output logic [7:0] r);
        m = '0; d = '0; r = '0;
        for (int i = 0; i < n; i++) begin
            beat(bits[n-1-i], 1'b0);
            m[n-1-i] = bus.match; d[n-1-i] = bus.done; r[n-1-i] = bus.cfg_ready;
        end
    endtask

    task automatic test_reset;
        tests_run++; if (bus.cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready: got %b expected 1", bus.cfg_ready); end
        tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests_run++; if ({bus.match, bus.done, bus.cfg_err} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b expected 000", {bus.match, bus.done, bus.cfg_err}); end
        tests_run++; if (bus.match_count !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", bus.match_count); end
        pulse_start(1'b0);
        tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL start_unloaded: got busy %b expected 0", bus.busy); end
    endtask

    task automatic test_nonoverlap;
        logic [7:0] m, d, r;
        cfg(8'b0001_0010, 4'd5, 1'b0, 8'd0);
        tests_run++; if (bus.cfg_err !== 1'b0) begin fails++; $display("FAIL legal_cfg_err: got %b expected 0", bus.cfg_err); end
        pulse_start(1'b0);
        tests_run++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL nonov_busy: got %b expected 1", bus.busy); end
        stream(8'b1001_0010, 8, m, d, r);
        tests_run++; if (m !== 8'b0000_1000) begin fails++; $display("FAIL nonov_match: got %b expected 00001000", m); end
        tests_run++; if (bus.match_count !== 8'd1) begin fails++; $display("FAIL nonov_count: got %0d expected 1", bus.match_count); end
        pulse_start(1'b1);
        tests_run++; if (bus.busy !== 1'b0 || bus.match_count !== 8'd1) begin fails++; $display("FAIL stop_hold: got busy %b count %0d expected 0 1", bus.busy, bus.match_count); end
    endtask

    task automatic test_overlap;
        logic [7:0] m, d, r;
        cfg(8'b0001_0010, 4'd5, 1'b1, 8'd0);
        pulse_start(1'b0);
        tests_run++; if (bus.match_count !== 8'd0) begin fails++; $display("FAIL start_clears_count: got %0d expected 0", bus.match_count); end
        stream(8'b1001_0010, 8, m, d, r);
        tests_run++; if (m !== 8'b0000_1001) begin fails++; $display("FAIL ov_match: got %b expected 00001001", m); end
        tests_run++; if (bus.match_count !== 8'd2) begin fails++; $display("FAIL ov_count: got %0d expected 2", bus.match_count); end
        tests_run++; if (d !== 8'd0) begin fails++; $display("FAIL ov_unlimited_done: got %b expected 00000000", d); end
        pulse_start(1'b1);
    endtask

    task automatic test_limit;
        logic [7:0] m, d, r;
        cfg(8'b0000_0011, 4'd2, 1'b1, 8'd3);
        pulse_start(1'b0);
        stream(8'b0011_1111, 6, m, d, r);
        tests_run++; if (m[5:0] !== 6'b011100) begin fails++; $display("FAIL lim_match: got %b expected 011100", m[5:0]); end
        tests_run++; if (d[5:0] !== 6'b000100) begin fails++; $display("FAIL lim_done: got %b expected 000100", d[5:0]); end
        tests_run++; if (r[5:0] !== 6'b000011) begin fails++; $display("FAIL lim_ready: got %b expected 000011", r[5:0]); end
        tests_run++; if (bus.match_count !== 8'd3 || bus.busy !== 1'b0) begin fails++; $display("FAIL lim_end: got count %0d busy %b expected 3 0", bus.match_count, bus.busy); end
    endtask

    task automatic test_cfg_err;
        logic [7:0] m, d, r;
        cfg(8'hFF, 4'd0, 1'b0, 8'd0);
        tests_run++; if (bus.cfg_err !== 1'b1) begin fails++; $display("FAIL err_len0: got %b expected 1", bus.cfg_err); end
        @(posedge clk); #1;
        tests_run++; if (bus.cfg_err !== 1'b0) begin fails++; $display("FAIL err_pulse_width: got %b expected 0", bus.cfg_err); end
        cfg(8'hFF, 4'd9, 1'b0, 8'd0);
        tests_run++; if (bus.cfg_err !== 1'b1) begin fails++; $display("FAIL err_len9: got %b expected 1", bus.cfg_err); end
        pulse_start(1'b0);
        stream(8'b0000_0011, 2, m, d, r);
        tests_run++; if (m[1:0] !== 2'b01 || bus.match_count !== 8'd1) begin fails++; $display("FAIL err_retained: got match %b count %0d expected 01 1", m[1:0], bus.match_count); end
        pulse_start(1'b1);
    endtask

    task automatic test_stop;
        pulse_start(1'b0);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        tests_run++; if (bus.match !== 1'b0 || bus.match_count !== 8'd0) begin fails++; $display("FAIL stop_discard: got match %b count %0d expected 0 0", bus.match, bus.match_count); end
        tests_run++; if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin fails++; $display("FAIL stop_idle: got busy %b ready %b expected 0 1", bus.busy, bus.cfg_ready); end
        pulse_start(1'b1);
        tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL start_stop_idle: got busy %b expected 0", bus.busy); end
    endtask

    task automatic test_async_reset;
        pulse_start(1'b0);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        tests_run++; if (bus.match !== 1'b1) begin fails++; $display("FAIL pre_reset_match: got %b expected 1", bus.match); end
        #2 reset_n = 1'b0;
        #1;
        tests_run++; if (bus.match !== 1'b0 || bus.match_count !== 8'd0) begin fails++; $display("FAIL async_clear: got match %b count %0d expected 0 0", bus.match, bus.match_count); end
        tests_run++; if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin fails++; $display("FAIL async_state: got busy %b ready %b expected 0 1", bus.busy, bus.cfg_ready); end
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        pulse_start(1'b0);
        tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_needs_cfg: got busy %b expected 0", bus.busy); end
        cfg(8'b0000_0011, 4'd2, 1'b1, 8'd0);
        pulse_start(1'b0);
        tests_run++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL recfg_start: got busy %b expected 1", bus.busy); end
    endtask

    initial begin
        bus.cfg_valid = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0; bus.cfg_limit = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.din_valid = 1'b0; bus.din = 1'b0;
        #13 reset_n = 1'b1;
        @(posedge clk); #1;
        test_reset;
        test_nonoverlap;
        test_overlap;
        test_limit;
        test_cfg_err;
        test_stop;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
